// File: rtl/bitm_seq_ctrl.sv
// bitm_seq_ctrl: multi-cycle fetch/decode/execute/mem/writeback controller with ext-unit op select
module bitm_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      instruction,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             ext_op,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic             alu_en,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_SW   = 6'h04;
    localparam logic [5:0] OP_BEQ  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h06;
    localparam logic [5:0] OP_HALT = 6'h3F;

    state_t     st;
    logic [5:0] op;
    logic [5:0] live_op;
    logic [5:0] cur_op;
    logic [4:0] wait_cnt;
    logic       waiting;
    logic       timed_out;
    logic       retire;
    logic       unused_bits;

    function automatic logic legal(input logic [5:0] o);
        return o inside {OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    function automatic logic uses_ext(input logic [5:0] o);
        return o inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ};
    endfunction

    assign live_op     = instruction[31:26];
    assign unused_bits = ^instruction[25:0];
    // DECODE sees the freshly loaded IR; later states use the latched opcode
    assign cur_op      = (st == DECODE) ? live_op : op;
    assign waiting     = (st == FETCH) || (st == MEM);
    // mem_ready in the final allowed cycle still completes the access
    assign timed_out   = waiting && !mem_ready && (wait_cnt == 5'(TIMEOUT - 1));
    assign retire      = (st == WB)
                      || (st == EXEC && (op == OP_BEQ || op == OP_J))
                      || (st == MEM && op == OP_SW && mem_ready);
    assign state       = st;

    // State sequencing, opcode latch, memory wait counter and retirement count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= IDLE;
            op       <= '0;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            wait_cnt <= (waiting && !mem_ready) ? wait_cnt + 5'd1 : 5'd0;
            retired  <= retired + CNT_W'(retire);
            if (st == DECODE) op <= live_op;
            case (st)
                IDLE:    if (start) st <= FETCH;
                FETCH:   if (mem_ready) st <= DECODE; else if (timed_out) st <= ERR;
                DECODE:  st <= (live_op == OP_HALT) ? HALT : !legal(live_op) ? ERR : EXEC;
                EXEC:    st <= (op == OP_ADD || op == OP_ADDI) ? WB
                             : (op == OP_LW || op == OP_SW) ? MEM : FETCH;
                MEM:     if (mem_ready) st <= (op == OP_LW) ? WB : FETCH; else if (timed_out) st <= ERR;
                WB:      st <= FETCH;
                default: st <= st;
            endcase
        end
    end

    // Datapath strobes; ir_we/pc_we/pc_src react to mem_ready and alu_zero in the same cycle
    always_comb begin
        ext_op  = (st == DECODE || st == EXEC || st == MEM || st == WB) && uses_ext(cur_op);
        ir_we   = (st == FETCH) && mem_ready;
        pc_we   = ir_we || (st == EXEC && (op == OP_J || (op == OP_BEQ && alu_zero)));
        pc_src  = (st == EXEC && op == OP_J) ? 2'd2
                : (st == EXEC && op == OP_BEQ && alu_zero) ? 2'd1 : 2'd0;
        alu_src = (st == EXEC) && ext_op;
        alu_en  = (st == EXEC);
        mem_rd  = (st == FETCH) || (st == MEM && op == OP_LW);
        mem_wr  = (st == MEM) && (op == OP_SW);
        reg_we  = (st == WB);
        illegal = (st == ERR);
    end
endmodule

// File: tb/tb_bitm_seq_ctrl.sv
// tb_bitm_seq_ctrl: scoreboard bench for the instruction sequencing controller
module tb_bitm_seq_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [31:0] instruction = '0;
    logic        mem_ready = 0;
    logic        alu_zero = 0;
    logic        ext_op, ir_we, pc_we, alu_src, alu_en, mem_rd, mem_wr, reg_we, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [15:0] retired;

    bitm_seq_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .ext_op(ext_op), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .alu_src(alu_src), .alu_en(alu_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we), .state(state),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        m;
        logic        z;
        logic        s;
        logic [31:0] i;
        logic [29:0] x;
    } cyc_t;

    cyc_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] ret = '0;
    logic [31:0] ins = '0;
    logic [29:0] obs;

    assign obs = {retired, state, ext_op, ir_we, pc_we, pc_src, alu_src, alu_en,
                  mem_rd, mem_wr, reg_we, illegal};

    function automatic logic [13:0] e(input logic [2:0] s, input logic x, input logic irw,
                                      input logic pcw, input logic [1:0] src, input logic as,
                                      input logic ae, input logic rd, input logic wr,
                                      input logic rw, input logic il);
        return {s, x, irw, pcw, src, as, ae, rd, wr, rw, il};
    endfunction

    task automatic push(input logic r, input logic m, input logic z, input logic s,
                        input logic [13:0] ex);
        cyc_t c;
        c.r = r; c.m = m; c.z = z; c.s = s; c.i = ins; c.x = {ret, ex};
        q.push_back(c);
    endtask

    task automatic test_reset;
        cyc_t c;
        int n = 0;
        ret = 0;
        push(1, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        push(1, 1, 1, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL reset cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi;
        cyc_t c;
        int n = 0;
        ins = 32'h0400FD72;
        push(1, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,0,0));
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,1,0,0,0,0,0,0,0,0,0));
        push(1, 0, 0, 0, e(3,1,0,0,0,1,1,0,0,0,0));
        push(1, 0, 0, 0, e(5,1,0,0,0,0,0,0,0,1,0));
        ret++;
        push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL addi cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw;
        cyc_t c;
        int n = 0;
        ins = 32'h0C0000AD;
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,1,0,0,0,0,0,0,0,0,0));
        push(1, 0, 0, 0, e(3,1,0,0,0,1,1,0,0,0,0));
        for (int i = 0; i < 3; i++) push(1, 0, 0, 0, e(4,1,0,0,0,0,0,1,0,0,0));
        push(1, 1, 0, 0, e(4,1,0,0,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(5,1,0,0,0,0,0,0,0,1,0));
        ret++;
        push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL lw cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw;
        cyc_t c;
        int n = 0;
        ins = 32'h10000004;
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,1,0,0,0,0,0,0,0,0,0));
        push(1, 0, 0, 0, e(3,1,0,0,0,1,1,0,0,0,0));
        push(1, 0, 0, 0, e(4,1,0,0,0,0,0,0,1,0,0));
        push(1, 1, 0, 0, e(4,1,0,0,0,0,0,0,1,0,0));
        ret++;
        push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL sw cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq;
        cyc_t c;
        int n = 0;
        ins = 32'h14000010;
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,1,0,0,0,0,0,0,0,0,0));
        push(1, 0, 1, 0, e(3,1,0,1,1,1,1,0,0,0,0));
        ret++;
        push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 1, 0, e(2,1,0,0,0,0,0,0,0,0,0));
        push(1, 0, 0, 0, e(3,1,0,0,0,1,1,0,0,0,0));
        ret++;
        push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL beq cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_j_halt;
        cyc_t c;
        int n = 0;
        ins = 32'h18001BA6;
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,0,0,0,0,0,0,0,0,0,0));
        push(1, 0, 0, 0, e(3,0,0,1,2,0,1,0,0,0,0));
        ret++;
        ins = 32'hFC000000;
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,0,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 20; i++)
            push(1, 1'($urandom), 1'($urandom), 1'(i), e(6,0,0,0,0,0,0,0,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL j_halt cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal;
        cyc_t c;
        int n = 0;
        ins = 32'h88000000;
        push(0, 0, 0, 1, e(6,0,0,0,0,0,0,0,0,0,0));
        ret = 0;
        push(1, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,0,0));
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,0,0,0,0,0,0,0,0,0,0));
        push(1, 1, 0, 1, e(7,0,0,0,0,0,0,0,0,0,1));
        push(1, 0, 1, 1, e(7,0,0,0,0,0,0,0,0,0,1));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL illegal cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout;
        cyc_t c;
        int n = 0;
        ins = 32'h00221820;
        push(0, 0, 0, 0, e(7,0,0,0,0,0,0,0,0,0,1));
        push(1, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 16; i++) push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        push(1, 1, 0, 0, e(7,0,0,0,0,0,0,0,0,0,1));
        push(0, 0, 0, 0, e(7,0,0,0,0,0,0,0,0,0,1));
        push(1, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 15; i++) push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,0,0,0,0,0,0,0,0,0,0));
        push(1, 0, 0, 0, e(3,0,0,0,0,0,1,0,0,0,0));
        push(1, 0, 0, 0, e(5,0,0,0,0,0,0,0,0,1,0));
        ret++;
        push(1, 0, 0, 0, e(1,0,0,0,0,0,0,1,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL timeout cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mem;
        cyc_t c;
        int n = 0;
        ins = 32'h0C0000AD;
        push(1, 1, 0, 0, e(1,0,1,1,0,0,0,1,0,0,0));
        push(1, 0, 0, 0, e(2,1,0,0,0,0,0,0,0,0,0));
        push(1, 0, 0, 0, e(3,1,0,0,0,1,1,0,0,0,0));
        push(1, 0, 0, 0, e(4,1,0,0,0,0,0,1,0,0,0));
        push(0, 0, 0, 0, e(4,1,0,0,0,0,0,1,0,0,0));
        ret = 0;
        push(1, 1, 1, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        push(1, 1, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.r; mem_ready = c.m; alu_zero = c.z; start = c.s; instruction = c.i;
            @(negedge clk);
            checks++;
            if (obs !== c.x) begin
                errors++;
                $display("FAIL reset_mid_mem cyc%0d retired=%0d want %0d strobes=%b want %b",
                         n, obs[29:14], c.x[29:14], obs[13:0], c.x[13:0]);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_addi;
        test_lw;
        test_sw;
        test_beq;
        test_j_halt;
        test_illegal;
        test_timeout;
        test_reset_mid_mem;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bitm_seq_ctrl.md
Name: bitm_seq_ctrl

Overview:
- Multi-cycle control FSM for the 32-bit processor.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the op select of the immediate bit-manipulation/sign-extension unit: 0 = pass the instruction word through, 1 = sign-extend bits [15:0] to 32 bits.
- Also produces register-file, PC, IR and memory strobes, and counts retired instructions.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_ready in FETCH or MEM before entering ERR; counter width is 5 bits.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- start, input, 1, begins execution when in IDLE.
- instruction, input, 32, current IR contents; opcode = instruction[31:26].
- mem_ready, input, 1, memory completion strobe for the current access.
- alu_zero, input, 1, ALU zero flag, used by BEQ.
- ext_op, output, 1, op select to the bit-manipulation unit.
- ir_we, output, 1, instruction register load.
- pc_we, output, 1, PC load.
- pc_src, output, 2, PC mux select: 0 = PC+4, 1 = branch target, 2 = jump target.
- alu_src, output, 1, ALU B operand: 0 = register, 1 = ext unit output.
- alu_en, output, 1, ALU operation strobe.
- mem_rd, output, 1, memory read request.
- mem_wr, output, 1, memory write request.
- reg_we, output, 1, register-file write.
- state, output, 3, current FSM state.
- illegal, output, 1, high while in ERR.
- retired, output, CNT_W, count of completed instructions.

Behaviour:
- Reset: when rst_n=0 at a clock edge, state <= IDLE, retired <= 0, wait counter <= 0. Reset applies from any state, including mid-memory-wait. Every output is 0 while in IDLE.
- Opcodes:
  - 0x00 ADD (register form)
  - 0x01 ADDI (sign-extended immediate)
  - 0x03 LW
  - 0x04 SW
  - 0x05 BEQ
  - 0x06 J
  - 0x3F HALT
  - any other value is illegal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Opcode latch: captured in DECODE and held until the next DECODE. All EXEC, MEM and WB decodes use the latched opcode, not live instruction bits.
- ext_op: 1 for ADDI, LW, SW, BEQ; 0 otherwise. Driven from DECODE through the last state of the instruction, and 0 in IDLE, FETCH, HALT and ERR.
- alu_src: equals ext_op in EXEC.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH:
  - mem_rd=1.
  - When mem_ready=1 in the same cycle: ir_we=1, pc_we=1, pc_src=0, then -> DECODE. ir_we and pc_we are Mealy outputs and are asserted only in that cycle.
- DECODE (1 cycle):
  - HALT -> HALT.
  - Illegal opcode -> ERR.
  - Everything else -> EXEC.
- EXEC (1 cycle), alu_en=1:
  - ADD/ADDI -> WB.
  - LW/SW -> MEM.
  - BEQ: if alu_zero=1, pc_we=1 and pc_src=1. Goes -> FETCH either way and counts as retired.
  - J: pc_we=1, pc_src=2, -> FETCH, retired.
- MEM:
  - mem_rd=1 for LW, mem_wr=1 for SW, held until mem_ready=1.
  - On mem_ready: LW -> WB; SW -> FETCH, retired.
- WB (1 cycle): reg_we=1, -> FETCH, retired.
- Retirement: retired increments by 1 on the clock edge that leaves the final state of the instruction, and wraps from 2^CNT_W-1 to 0. HALT itself is not counted.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle while waiting with mem_ready=0.
  - If it reaches TIMEOUT without mem_ready -> ERR.
  - If mem_ready arrives in the same cycle the count reaches TIMEOUT, mem_ready wins and the access completes.
- HALT and ERR: absorbing until reset; start is ignored. illegal=1 only in ERR.
- start is ignored outside IDLE.

Test Plan:
- Reset: drive rst_n=0 mid-MEM wait -> next edge state=0, retired=0, all strobes 0.
- ADDI 0x0400FD72: start, mem_ready on the first FETCH cycle -> states 1,2,3,5,1. ext_op=1 through DECODE/EXEC/WB, alu_src=1 in EXEC, reg_we one cycle, retired=1.
- LW 0x0C0000AD with mem_ready delayed 3 cycles in MEM -> mem_rd held 4 cycles, then WB, reg_we=1, retired increments.
- BEQ 0x14000010: alu_zero=1 -> pc_we=1 with pc_src=1 in EXEC. Repeat with alu_zero=0 -> pc_we=0; both cases return to FETCH.
- J 0x18001BA6 -> ext_op=0, pc_src=2 with pc_we in EXEC. Then opcode 0x3F -> state=6 held for 20 cycles; start pulses ignored.
- Opcode 0x22 -> ERR, illegal=1. Separately, mem_ready held 0 in FETCH -> ERR after exactly TIMEOUT=16 wait cycles; with mem_ready on cycle 16 -> DECODE.
